// File: rtl/ibex_bus_arb.sv
// ibex_bus_arb: shares one Ibex-style req/gnt/rvalid host port between the instruction-fetch
// and data-LSU interfaces of the core.
//
// A requester that has been presented but not yet granted is locked onto the host port, so
// the request and address stay stable until gnt. Accepted requests push their requester ID
// into an in-order FIFO. Each response pops the head ID and is routed back to that requester.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset (all outputs read 0 while high)
//   instr_*                fetch request/response interface (read-only, full word)
//   data_*                 LSU request/response interface
//   host_*                 arbitrated req/gnt/rvalid port towards the TL-UL host adapter
//   busy_o                 transactions outstanding or a request is being presented
//   protocol_err_o         sticky: a response arrived with no outstanding transaction
//   perf_*_stall_o         16-bit saturating stall-cycle counters
//
// Configuration:
//   IBEX_BUS_ARB_PERF_EN   when defined, the stall counters are implemented; otherwise both
//                          perf outputs are tied to 0 and no counter flops exist.
module ibex_bus_arb #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        host_req_o,
  output logic        host_type_o,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_gnt_i,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i,

  output logic        busy_o,
  output logic        protocol_err_o,
  output logic [15:0] perf_instr_stall_o,
  output logic [15:0] perf_data_stall_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);

  // Requester IDs: 0 = instruction, 1 = data.
  logic [MaxOutstanding-1:0] ids_q, ids_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      lock_vld_q, lock_vld_d;
  logic                      lock_id_q, lock_id_d;
  logic                      last_grant_q, last_grant_d;
  logic                      protocol_err_q, protocol_err_d;

  logic sel;
  logic full, empty;
  logic req_raw;
  logic accept;
  logic pop;
  logic head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CntFull);
  assign empty = (cnt_q == '0);
  assign head  = ids_q[rd_ptr_q];

  always_comb begin
    if (lock_vld_q) begin
      sel = lock_id_q;
    end else if (instr_req_i && data_req_i) begin
      sel = RoundRobin ? ~last_grant_q : 1'b1;
    end else begin
      sel = data_req_i;
    end
  end

  // No full bypass: a pop in the same cycle does not free a slot for this cycle's request.
  assign req_raw = (lock_vld_q | instr_req_i | data_req_i) & ~full;
  assign accept  = host_req_o & host_gnt_i;
  assign pop     = ~rst_i & host_rvalid_i & ~empty;

  // Request side
  assign host_req_o   = ~rst_i & req_raw;
  assign host_type_o  = ~rst_i & sel;
  assign host_addr_o  = rst_i ? '0 : (sel ? data_addr_i : instr_addr_i);
  assign host_we_o    = ~rst_i & sel & data_we_i;
  assign host_be_o    = rst_i ? '0 : (sel ? data_be_i : 4'hF);
  assign host_wdata_o = (~rst_i & sel) ? data_wdata_i : '0;

  assign instr_gnt_o = accept & ~sel;
  assign data_gnt_o  = accept & sel;

  // Response side
  assign instr_rvalid_o = pop & ~head;
  assign data_rvalid_o  = pop & head;
  assign instr_rdata_o  = instr_rvalid_o ? host_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? host_rdata_i : '0;
  assign instr_err_o    = instr_rvalid_o & host_err_i;
  assign data_err_o     = data_rvalid_o & host_err_i;

  assign busy_o         = ~rst_i & (~empty | req_raw);
  assign protocol_err_o = ~rst_i & protocol_err_q;

  always_comb begin
    ids_d          = ids_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q;
    lock_vld_d     = lock_vld_q;
    lock_id_d      = lock_id_q;
    last_grant_d   = last_grant_q;
    protocol_err_d = protocol_err_q;

    if (accept) begin
      ids_d[wr_ptr_q] = sel;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      lock_vld_d      = 1'b0;
      last_grant_d    = sel;
    end else if (host_req_o) begin
      lock_vld_d = 1'b1;
      lock_id_d  = sel;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (host_rvalid_i && empty) begin
      protocol_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ids_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      lock_vld_q     <= 1'b0;
      lock_id_q      <= 1'b0;
      last_grant_q   <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      ids_q          <= ids_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      lock_vld_q     <= lock_vld_d;
      lock_id_q      <= lock_id_d;
      last_grant_q   <= last_grant_d;
      protocol_err_q <= protocol_err_d;
    end
  end

`ifdef IBEX_BUS_ARB_PERF_EN
  logic [15:0] perf_instr_q, perf_instr_d;
  logic [15:0] perf_data_q, perf_data_d;

  always_comb begin
    perf_instr_d = perf_instr_q;
    perf_data_d  = perf_data_q;
    if (instr_req_i && !instr_gnt_o && (perf_instr_q != 16'hFFFF)) begin
      perf_instr_d = perf_instr_q + 16'd1;
    end
    if (data_req_i && !data_gnt_o && (perf_data_q != 16'hFFFF)) begin
      perf_data_d = perf_data_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_instr_q <= '0;
      perf_data_q  <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_data_q  <= perf_data_d;
    end
  end

  assign perf_instr_stall_o = rst_i ? '0 : perf_instr_q;
  assign perf_data_stall_o  = rst_i ? '0 : perf_data_q;
`else
  assign perf_instr_stall_o = '0;
  assign perf_data_stall_o  = '0;
`endif

endmodule

// File: doc/ibex_bus_arb.md
Name: ibex_bus_arb

Overview:
- Shares one Ibex-style req/gnt/rvalid host port between the core instruction-fetch and data-LSU interfaces.
- The host port feeds a single tlul_adapter_host, so one TL-UL port serves both streams.
- Arbitrates with a request lock, which satisfies the Ibex rule that req and address stay stable until gnt.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to its requester.

Parameters:
MaxOutstanding, 2, depth of the requester-ID FIFO; maximum accepted-but-unanswered transactions (range 1..8).
RoundRobin, 1'b1, 1 = alternate on contention; 0 = fixed priority, data wins.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
instr_req_i  in  1  fetch request
instr_addr_i  in  32  fetch address
instr_gnt_o  out  1  fetch request accepted
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch response data
instr_err_o  out  1  fetch response error
data_req_i  in  1  LSU request
data_we_i  in  1  LSU write enable
data_be_i  in  4  LSU byte enables
data_addr_i  in  32  LSU address
data_wdata_i  in  32  LSU write data
data_gnt_o  out  1  LSU request accepted
data_rvalid_o  out  1  LSU response valid
data_rdata_o  out  32  LSU response data
data_err_o  out  1  LSU response error
host_req_o  out  1  request to adapter
host_type_o  out  1  0 = instruction, 1 = data
host_addr_o  out  32  muxed address
host_we_o  out  1  muxed write enable; 0 for instruction
host_be_o  out  4  muxed byte enables; 4'hF for instruction
host_wdata_o  out  32  muxed write data; 0 for instruction
host_gnt_i  in  1  adapter accepted request
host_rvalid_i  in  1  adapter response valid
host_rdata_i  in  32  adapter response data
host_err_i  in  1  adapter response error
busy_o  out  1  FIFO non-empty or host_req_o high
protocol_err_o  out  1  sticky: rvalid received with FIFO empty
perf_instr_stall_o  out  16  instruction stall cycles (optional feature)
perf_data_stall_o  out  16  data stall cycles (optional feature)

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - FIFO emptied, lock cleared, last_grant = instruction, protocol_err_o = 0, perf counters = 0.
  - While rst_i is held, all outputs read 0.
  - Reset mid-transaction drops all outstanding IDs; late responses afterwards set protocol_err_o.
- Selection (combinational, same cycle):
  - If lock_vld, sel = lock_id.
  - Else, with a single requester, sel = that requester.
  - Else, with both requesting: RoundRobin=1 picks the one not equal to last_grant; RoundRobin=0 picks data.
- host_req_o = (lock_vld or instr_req_i or data_req_i) and FIFO not full.
  - Full blocks requests even if a pop occurs the same cycle; there is no bypass.
- host_type_o and the payload signals follow sel; instruction payload is constant as listed in Ports.
- Grant is zero-latency: instr_gnt_o = host_req_o & host_gnt_i & (sel == 0); data_gnt_o likewise for sel == 1.
- Lock:
  - On host_req_o & !host_gnt_i: lock_vld <= 1, lock_id <= sel.
  - On host_req_o & host_gnt_i: lock_vld <= 0 and last_grant <= sel.
- ID FIFO:
  - Push sel on host_req_o & host_gnt_i; pop on host_rvalid_i.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo MaxOutstanding.
- Response routing (combinational, zero latency):
  - instr_rvalid_o = host_rvalid_i & !empty & (head == 0); data_rvalid_o likewise for head == 1.
  - rdata and err are routed to the same requester; the non-selected requester's rdata/err outputs read 0.
- host_rvalid_i with the FIFO empty: response dropped, no pop, protocol_err_o set until reset.
- Responses return in order; the block never reorders.
- busy_o is combinational.

Optional Feature:
- Macro: IBEX_BUS_ARB_PERF_EN.
- Defined: two 16-bit saturating counters increment each cycle their requester has req high and gnt low. They hold at 16'hFFFF and clear only on reset.
- Undefined: no counter flops; both perf outputs are tied to 0.

Test Plan:
- Single instruction: instr_req_i=1, addr 0x100, host_gnt_i=1 the same cycle → instr_gnt_o=1, host_type_o=0, host_be_o=4'hF. Response 0xDEADBEEF two cycles later → instr_rvalid_o=1 with that data; data_rvalid_o=0.
- Contention, RoundRobin=1, both requesting, host_gnt_i=1 every cycle → grants data, instr, data, instr. After reset the first grant is data.
- Lock: data requests with host_gnt_i=0 for 3 cycles, instr_req_i rises on cycle 2 → host_addr_o holds the data address until gnt; instr is granted next.
- Full: MaxOutstanding=2, two grants with no rvalid → host_req_o=0 and both gnt=0. One rvalid → host_req_o=1 on the next cycle.
- Out-of-order bookkeeping: grant instr then data; rvalid with host_err_i=1, then rvalid → instr_err_o=1 first, then data_rvalid_o. A third rvalid with the FIFO empty → protocol_err_o=1 and sticky.
- With IBEX_BUS_ARB_PERF_EN: instr stalled 5 cycles → perf_instr_stall_o=5. Force 70000 stall cycles → output saturates at 0xFFFF.
